// File: rtl/ffe_prog_ntap.sv
// Programmable N-tap feed-forward equalizer for the TX path.
// Symbols (NRZ or PAM4) shift through a tap line that tracks which taps hold
// real data. Each output is the saturated sum of signed weights times symbols.
// Weights are written into a shadow bank and copied into the active bank in one
// step, so the filter never runs with a half-updated weight set.
module ffe_prog_ntap #(
    parameter int NTAP     = 4,
    parameter int WW       = 6,
    parameter int OW       = 10,
    parameter int MAIN     = 0,
    parameter int RST_MAIN = 16,
    localparam int AW      = (NTAP > 1) ? $clog2(NTAP) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [1:0]           din,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [AW-1:0]        cfg_addr,
    input  logic signed [WW-1:0] cfg_data,
    input  logic                 cfg_commit,
    output logic                 cfg_err,
    output logic signed [OW-1:0] out_code,
    output logic                 out_valid,
    output logic                 sat
);

    // Fill counter width, holds 0..NTAP
    localparam int CW      = $clog2(NTAP + 1);
    // Each product fits in WW+2 bits (|sym| <= 3); NTAP products add clog2(NTAP).
    // The sum is also kept wider than the output so the clip bounds are representable.
    localparam int SUM_MIN = WW + 3 + $clog2(NTAP);
    localparam int SW      = (SUM_MIN > OW) ? SUM_MIN : OW + 1;

    localparam logic signed [SW-1:0] OUT_MAX = SW'((2 ** (OW - 1)) - 1);
    localparam logic signed [SW-1:0] OUT_MIN = SW'(-(2 ** (OW - 1)));

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0]           state;
    logic signed [WW-1:0] shadow  [NTAP];
    logic signed [WW-1:0] active  [NTAP];
    logic signed [2:0]    tap_sym [NTAP];
    logic [NTAP-1:0]      tap_fill;
    logic [CW-1:0]        fill_cnt;
    logic                 mode_q;

    logic                 mode_change;
    logic                 addr_ok;
    logic signed [2:0]    sym_in;
    logic signed [SW-1:0] sum;
    logic signed [OW-1:0] clipped;
    logic                 clip_hit;

    assign mode_change = (mode != mode_q);
    assign addr_ok     = (32'(cfg_addr) < 32'(NTAP));
    assign cfg_ready   = (state == ST_IDLE);

    // Map the incoming symbol to its signed level for the current mode
    always_comb begin
        sym_in = 3'sd0;
        if (mode) begin
            case (din)
                2'b00:   sym_in = -3'sd3;
                2'b01:   sym_in = -3'sd1;
                2'b10:   sym_in = 3'sd1;
                default: sym_in = 3'sd3;
            endcase
        end else begin
            sym_in = din[0] ? 3'sd1 : -3'sd1;
        end
    end

    // Full-precision weighted sum over the filled taps only
    always_comb begin
        sum = '0;
        for (int i = 0; i < NTAP; i++) begin
            if (tap_fill[i]) begin
                sum = sum + SW'(active[i]) * SW'(tap_sym[i]);
            end
        end
    end

    // Clip the sum into the signed output range and flag when that happens
    always_comb begin
        clip_hit = 1'b0;
        clipped  = sum[OW-1:0];
        if (sum > OUT_MAX) begin
            clipped  = OUT_MAX[OW-1:0];
            clip_hit = 1'b1;
        end else if (sum < OUT_MIN) begin
            clipped  = OUT_MIN[OW-1:0];
            clip_hit = 1'b1;
        end
    end

    // Output register: one symbol of latency, frozen while en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            out_code  <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
        end else if (en) begin
            out_code  <= clipped;
            out_valid <= (fill_cnt == CW'(NTAP));
            sat       <= clip_hit;
        end
    end

    // Tap line and fill tracking; a mode change empties the line instead of shifting
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= mode;
            tap_fill <= '0;
            fill_cnt <= '0;
            for (int i = 0; i < NTAP; i++) begin
                tap_sym[i] <= '0;
            end
        end else begin
            mode_q <= mode;
            if (mode_change) begin
                tap_fill <= '0;
                fill_cnt <= '0;
            end else if (en) begin
                tap_sym[0]  <= sym_in;
                tap_fill[0] <= 1'b1;
                for (int i = 1; i < NTAP; i++) begin
                    tap_sym[i]  <= tap_sym[i-1];
                    tap_fill[i] <= tap_fill[i-1];
                end
                if (fill_cnt != CW'(NTAP)) begin
                    fill_cnt <= fill_cnt + CW'(1);
                end
            end
        end
    end

    // Config FSM: shadow writes in IDLE, atomic shadow-to-active copy on the first enabled edge in PEND
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cfg_err <= 1'b0;
            for (int i = 0; i < NTAP; i++) begin
                shadow[i] <= (i == MAIN) ? WW'(RST_MAIN) : WW'(0);
                active[i] <= (i == MAIN) ? WW'(RST_MAIN) : WW'(0);
            end
        end else begin
            cfg_err <= (state == ST_IDLE) && cfg_valid && !addr_ok;
            case (state)
                ST_IDLE: begin
                    if (cfg_valid && addr_ok) begin
                        shadow[cfg_addr] <= cfg_data;
                    end
                    if (cfg_commit) begin
                        state <= ST_PEND;
                    end
                end
                default: begin
                    if (en) begin
                        for (int i = 0; i < NTAP; i++) begin
                            active[i] <= shadow[i];
                        end
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ffe_prog_ntap.sv
// Testbench for ffe_prog_ntap.
// Two instances share one stimulus stream: 'a' uses the default parameters,
// 'b' uses NTAP=5 / OW=8 so that saturation and out-of-range addresses are reachable.
// A behavioural model (integer history arrays and weight tables) predicts every
// output of both instances each cycle; directed literal values pin the model.
module tb_ffe_prog_ntap;

    logic              clk;
    logic              rst;
    logic              en;
    logic              mode;
    logic [1:0]        din;
    logic              cfg_valid;
    logic              cfg_commit;
    logic [2:0]        cfg_addr;
    logic signed [5:0] cfg_data;

    logic              a_ready, a_err, a_valid, a_sat;
    logic signed [9:0] a_out;
    logic              b_ready, b_err, b_valid, b_sat;
    logic signed [7:0] b_out;

    int checks = 0;
    int errors = 0;

    // Instance 'a' has a 2-bit address port, so it only sees the low address bits
    ffe_prog_ntap dut_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .din        (din),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (a_ready),
        .cfg_addr   (cfg_addr[1:0]),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_err    (a_err),
        .out_code   (a_out),
        .out_valid  (a_valid),
        .sat        (a_sat)
    );

    ffe_prog_ntap #(.NTAP(5), .OW(8)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .din        (din),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (b_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_err    (b_err),
        .out_code   (b_out),
        .out_valid  (b_valid),
        .sat        (b_sat)
    );

    // Symbol clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    int   m_ntap [2] = '{4, 5};
    int   m_ow   [2] = '{10, 8};
    int   sh     [2][5];
    int   ac     [2][5];
    int   hist   [2][5];
    int   hlen   [2];
    bit   pend   [2];
    logic mprev  [2];
    int   e_out  [2];
    int   e_valid[2];
    int   e_sat  [2];
    int   e_err  [2];
    int   e_ready[2];
    bit   model_live = 1'b0;

    function automatic int map_sym(input logic m, input logic [1:0] d);
        if (m) return 2 * int'(d) - 3;
        return d[0] ? 1 : -1;
    endfunction

    task automatic model_step(input int k);
        int a;
        int s;
        int lim;
        a = (k == 0) ? int'(cfg_addr[1:0]) : int'(cfg_addr);
        if (rst) begin
            for (int j = 0; j < 5; j++) begin
                sh[k][j] = (j == 0) ? 16 : 0;
                ac[k][j] = (j == 0) ? 16 : 0;
            end
            hlen[k]  = 0;
            pend[k]  = 1'b0;
            mprev[k] = mode;
            e_out[k] = 0;
            e_valid[k] = 0;
            e_sat[k] = 0;
            e_err[k] = 0;
        end else begin
            e_err[k] = (!pend[k] && cfg_valid && a >= m_ntap[k]) ? 1 : 0;
            if (en) begin
                s = 0;
                for (int j = 0; j < hlen[k]; j++) s += ac[k][j] * hist[k][j];
                lim = 1 << (m_ow[k] - 1);
                if (s > lim - 1) begin
                    e_out[k] = lim - 1;
                    e_sat[k] = 1;
                end else if (s < -lim) begin
                    e_out[k] = -lim;
                    e_sat[k] = 1;
                end else begin
                    e_out[k] = s;
                    e_sat[k] = 0;
                end
                e_valid[k] = (hlen[k] == m_ntap[k]) ? 1 : 0;
            end
            if (!pend[k]) begin
                if (cfg_valid && a < m_ntap[k]) sh[k][a] = int'(cfg_data);
                if (cfg_commit) pend[k] = 1'b1;
            end else if (en) begin
                for (int j = 0; j < 5; j++) ac[k][j] = sh[k][j];
                pend[k] = 1'b0;
            end
            if (mode != mprev[k]) begin
                hlen[k] = 0;
            end else if (en) begin
                for (int j = 4; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = map_sym(mode, din);
                if (hlen[k] < m_ntap[k]) hlen[k]++;
            end
            mprev[k] = mode;
        end
        e_ready[k] = pend[k] ? 0 : 1;
    endtask

    // Advance the model on every active edge with the same inputs the DUTs see
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
        if (rst) model_live = 1'b1;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output of both instances against the model, away from the active edge
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("a_out_code",  int'(a_out),   e_out[0]);
            checkOutput("a_out_valid", int'(a_valid), e_valid[0]);
            checkOutput("a_sat",       int'(a_sat),   e_sat[0]);
            checkOutput("a_cfg_err",   int'(a_err),   e_err[0]);
            checkOutput("a_cfg_ready", int'(a_ready), e_ready[0]);
            checkOutput("b_out_code",  int'(b_out),   e_out[1]);
            checkOutput("b_out_valid", int'(b_valid), e_valid[1]);
            checkOutput("b_sat",       int'(b_sat),   e_sat[1]);
            checkOutput("b_cfg_err",   int'(b_err),   e_err[1]);
            checkOutput("b_cfg_ready", int'(b_ready), e_ready[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic e, input logic m, input logic [1:0] d, input int n);
        en         = e;
        mode       = m;
        din        = d;
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
        tick(n);
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic signed [5:0] data,
                             input logic commit, input logic valid);
        cfg_valid  = valid;
        cfg_addr   = addr;
        cfg_data   = data;
        cfg_commit = commit;
        tick(1);
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; din = 2'b00;
        cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_data = '0;
        tick(2);
        rst = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst_out_code",  int'(a_out),   0);
        checkOutput("rst_out_valid", int'(a_valid), 0);
        checkOutput("rst_sat",       int'(a_sat),   0);
        checkOutput("rst_cfg_ready", int'(a_ready), 1);
        checkOutput("rst_cfg_err",   int'(a_err),   0);

        $display("[TB] NRZ defaults, din=1");
        applyStimulus(1'b1, 1'b0, 2'b01, 1);
        checkOutput("nrz_edge1_out", int'(a_out), 0);
        applyStimulus(1'b1, 1'b0, 2'b01, 1);
        checkOutput("nrz_edge2_out_a", int'(a_out), 16);
        checkOutput("nrz_edge2_out_b", int'(b_out), 16);
        applyStimulus(1'b1, 1'b0, 2'b01, 2);
        checkOutput("nrz_edge4_valid", int'(a_valid), 0);
        applyStimulus(1'b1, 1'b0, 2'b01, 1);
        checkOutput("nrz_edge5_valid_a", int'(a_valid), 1);
        checkOutput("nrz_edge5_valid_b", int'(b_valid), 0);
        applyStimulus(1'b1, 1'b0, 2'b01, 1);
        checkOutput("nrz_edge6_valid_b", int'(b_valid), 1);

        $display("[TB] program {20,-4,2,0}, PAM4");
        cfg_write(3'd0, 6'sd20, 1'b0, 1'b1);
        cfg_write(3'd1, -6'sd4, 1'b0, 1'b1);
        cfg_write(3'd2, 6'sd2,  1'b0, 1'b1);
        cfg_write(3'd3, 6'sd0,  1'b0, 1'b1);
        cfg_write(3'd0, 6'sd0,  1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b11, 8);
        checkOutput("pam4_full_out_a", int'(a_out), 54);
        checkOutput("pam4_full_sat_a", int'(a_sat), 0);
        checkOutput("pam4_full_out_b", int'(b_out), 54);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, (i % 2 == 0) ? 2'b00 : 2'b11, 1);
            if (i >= 2) checkOutput("pam4_alt_out", int'(a_out), (i % 2 == 0) ? 78 : -78);
        end

        $display("[TB] saturation, all taps 31");
        for (int i = 0; i < 4; i++) cfg_write(3'(i), 6'sd31, 1'b0, 1'b1);
        cfg_write(3'd0, 6'sd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b11, 8);
        checkOutput("sat_pos_out_a", int'(a_out), 372);
        checkOutput("sat_pos_sat_a", int'(a_sat), 0);
        checkOutput("sat_pos_out_b", int'(b_out), 127);
        checkOutput("sat_pos_sat_b", int'(b_sat), 1);
        applyStimulus(1'b1, 1'b1, 2'b00, 8);
        checkOutput("sat_neg_out_a", int'(a_out), -372);
        checkOutput("sat_neg_out_b", int'(b_out), -128);
        checkOutput("sat_neg_sat_b", int'(b_sat), 1);

        $display("[TB] commit held off by en=0");
        en = 1'b0;
        cfg_write(3'd0, 6'sd10, 1'b0, 1'b1);
        cfg_write(3'd0, 6'sd0,  1'b1, 1'b0);
        cfg_write(3'd2, 6'sd9,  1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'b00, 3);
        checkOutput("pend_ready", int'(a_ready), 0);
        checkOutput("pend_hold_out", int'(a_out), -372);
        applyStimulus(1'b1, 1'b1, 2'b11, 1);
        checkOutput("copy_ready", int'(a_ready), 1);
        checkOutput("copy_edge_out", int'(a_out), -372);
        applyStimulus(1'b1, 1'b1, 2'b11, 5);
        checkOutput("post_copy_out_a", int'(a_out), 309);
        checkOutput("post_copy_out_b", int'(b_out), 127);

        $display("[TB] simultaneous write and commit, bad address");
        cfg_write(3'd2, 6'sd0, 1'b0, 1'b1);
        cfg_write(3'd3, 6'sd0, 1'b0, 1'b1);
        cfg_write(3'd1, -6'sd8, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'b11, 6);
        checkOutput("wr_commit_out_a", int'(a_out), 6);
        checkOutput("wr_commit_out_b", int'(b_out), 6);
        // Address 5 is out of range for 'b'; 'a' sees only address bits [1:0] = 1
        cfg_write(3'd5, 6'sd7, 1'b0, 1'b1);
        checkOutput("bad_addr_err_b", int'(b_err), 1);
        checkOutput("bad_addr_err_a", int'(a_err), 0);
        applyStimulus(1'b1, 1'b1, 2'b11, 1);
        checkOutput("bad_addr_err_pulse_b", int'(b_err), 0);
        cfg_write(3'd0, 6'sd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b11, 4);
        checkOutput("bad_addr_shadow_b", int'(b_out), 6);
        checkOutput("trunc_addr_out_a", int'(a_out), 51);

        $display("[TB] mode toggle mid-stream");
        begin
            int exp_out[6]   = '{51, 0, 10, 17, 17, 17};
            int exp_valid[6] = '{1, 0, 0, 0, 0, 1};
            for (int i = 0; i < 6; i++) begin
                applyStimulus(1'b1, 1'b0, 2'b01, 1);
                checkOutput("toggle_out_a",   int'(a_out),   exp_out[i]);
                checkOutput("toggle_valid_a", int'(a_valid), exp_valid[i]);
            end
            checkOutput("toggle_partial_b", int'(b_out), 2);
        end

        $display("[TB] reset while commit pending");
        en = 1'b0;
        cfg_write(3'd0, 6'sd0, 1'b1, 1'b0);
        checkOutput("pend_before_rst", int'(a_ready), 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("rst_in_pend_ready", int'(a_ready), 1);
        checkOutput("rst_in_pend_out",   int'(a_out),   0);
        applyStimulus(1'b1, 1'b0, 2'b01, 6);
        checkOutput("rst_defaults_out_a", int'(a_out), 16);
        checkOutput("rst_defaults_out_b", int'(b_out), 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
